decode_exec_skid: RTL and testbench

//  Decode-to-execute pipeline stage. Captures the extended immediate from the immediate extender,

---
 rtl/hybrid_pkg.sv | 22 ++
 rtl/pipe_slot.sv | 19 +
 rtl/decode_exec_skid.sv | 123 ++++++++++++
 tb/tb_decode_exec_skid.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/hybrid_pkg.sv
// Shared types for the decode-to-execute skid stage: default payload widths,
// the skid FSM state encoding and the packed payload layout.
package hybrid_pkg;
  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int CTRL_W = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  // Field order matches the flat payload vector built in decode_exec_skid.
  typedef struct packed {
    logic [DATA_W-1:0] extimm;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [REG_AW-1:0] wa3;
    logic [CTRL_W-1:0] ctrl;
  } dex_payload_t;
endpackage

// File: rtl/pipe_slot.sv
// Loadable payload register with load enable; async reset clears it to zero.
module pipe_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_q <= '0;
    else if (i_load) r_q <= i_d;
  end

  assign o_q = r_q;
endmodule

// File: rtl/decode_exec_skid.sv
// Decode-to-execute stage: 2-entry skid buffer (main + skid slot) whose ready and
// valid decode from state only, with sync flush and a saturating back-pressure counter.
//
//  state | meaning
//  EMPTY | no beat held; out_valid=0, in_ready=1
//  BUSY  | main slot holds the head beat
//  FULL  | main and skid both hold beats; input blocked
module decode_exec_skid #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_extimm,
  input  logic [DATA_W-1:0] in_rd1,
  input  logic [DATA_W-1:0] in_rd2,
  input  logic [REG_AW-1:0] in_wa3,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_extimm,
  output logic [DATA_W-1:0] out_rd1,
  output logic [DATA_W-1:0] out_rd2,
  output logic [REG_AW-1:0] out_wa3,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);
  import hybrid_pkg::*;

  localparam int PL_W = 3*DATA_W + REG_AW + CTRL_W;

  skid_state_t     r_state, w_state_nxt;
  logic            w_in_ready, w_out_valid;
  logic            w_in_fire, w_out_fire;
  logic            w_main_load, w_skid_load, w_main_from_skid;
  logic [PL_W-1:0] w_in_pl, w_main_d, w_main_q, w_skid_q;
  logic [CNT_W-1:0] r_stall_cnt;

  assign w_in_ready  = (r_state != FULL);
  assign w_out_valid = (r_state != EMPTY);
  assign w_in_fire   = in_valid & w_in_ready;
  assign w_out_fire  = w_out_valid & out_ready;
  assign w_in_pl     = {in_extimm, in_rd1, in_rd2, in_wa3, in_ctrl};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= EMPTY;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_main_load      = 1'b0;
    w_skid_load      = 1'b0;
    w_main_from_skid = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_in_fire) begin
          w_main_load = 1'b1;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (w_in_fire && w_out_fire) begin
          w_main_load = 1'b1;
        end else if (w_in_fire) begin
          w_skid_load = 1'b1;
          w_state_nxt = FULL;
        end else if (w_out_fire) begin
          w_state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (w_out_fire) begin
          w_main_load      = 1'b1;
          w_main_from_skid = 1'b1;
          w_state_nxt      = BUSY;
        end
      end
      default: w_state_nxt = EMPTY;
    endcase
    // Flush wins: any beat captured this cycle is dropped; payload regs keep stale data.
    if (flush) begin
      w_state_nxt = EMPTY;
      w_main_load = 1'b0;
      w_skid_load = 1'b0;
    end
  end

  assign w_main_d = w_main_from_skid ? w_skid_q : w_in_pl;

  pipe_slot #(.W(PL_W)) u_main (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_main_load),
    .i_d    (w_main_d),
    .o_q    (w_main_q)
  );

  pipe_slot #(.W(PL_W)) u_skid (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_skid_load),
    .i_d    (w_in_pl),
    .o_q    (w_skid_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_stall_cnt <= '0;
    else if (w_out_valid && !out_ready && (r_stall_cnt != {CNT_W{1'b1}}))
      r_stall_cnt <= r_stall_cnt + 1'b1;
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign {out_extimm, out_rd1, out_rd2, out_wa3, out_ctrl} = w_main_q;
  assign stall_cnt = r_stall_cnt;
endmodule

// File: tb/tb_decode_exec_skid.sv
// Scoreboard bench for decode_exec_skid: accepted beats queue up as expected output,
// a negedge monitor checks handshake, payload order and the stall counter.
module tb_decode_exec_skid;
  import hybrid_pkg::*;

  localparam int CNT_W = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [31:0]       in_extimm = '0, in_rd1 = '0, in_rd2 = '0;
  logic [4:0]        in_wa3 = '0;
  logic [7:0]        in_ctrl = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [31:0]       out_extimm, out_rd1, out_rd2;
  logic [4:0]        out_wa3;
  logic [7:0]        out_ctrl;
  logic [CNT_W-1:0]  stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int n_out   = 0;
  bit mon_en  = 1'b0;
  dex_payload_t q_exp[$];
  logic [CNT_W-1:0] exp_stall = '0;
  dex_payload_t in_pl, out_pl;

  assign in_pl  = {in_extimm, in_rd1, in_rd2, in_wa3, in_ctrl};
  assign out_pl = {out_extimm, out_rd1, out_rd2, out_wa3, out_ctrl};

  always #5 clk = ~clk;

  decode_exec_skid #(.DATA_W(32), .REG_AW(5), .CTRL_W(8), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_extimm(in_extimm), .in_rd1(in_rd1), .in_rd2(in_rd2), .in_wa3(in_wa3), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_extimm(out_extimm), .out_rd1(out_rd1), .out_rd2(out_rd2), .out_wa3(out_wa3),
    .out_ctrl(out_ctrl), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      chk("in_ready", in_ready, q_exp.size() < 2);
      chk("out_valid", out_valid, q_exp.size() != 0);
      chk("stall_cnt", stall_cnt, exp_stall);
      if (q_exp.size() != 0 && !out_ready && exp_stall != {CNT_W{1'b1}})
        exp_stall = exp_stall + 1'b1;
      if (out_valid && out_ready && q_exp.size() != 0) begin
        chk("payload", out_pl, q_exp.pop_front());
        n_out++;
      end
      if (flush) q_exp.delete();
      else if (in_valid && in_ready) q_exp.push_back(in_pl);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input logic [31:0] ext, input logic [4:0] wa3);
    in_extimm = ext;
    in_rd1    = $urandom;
    in_rd2    = $urandom;
    in_wa3    = wa3;
    in_ctrl   = 8'($urandom);
  endtask

  int base;

  initial begin
    // reset state
    #2;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_payload", out_pl, '0);
    chk("rst_stall", stall_cnt, '0);
    tick(); tick();
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // 1: single beat
    out_ready = 1'b1;
    set_beat(32'hFFFF_FFF6, 5'd3);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("t1_one_out", n_out, 1);

    // 2: 8 back-to-back beats
    base = n_out;
    for (int i = 0; i < 8; i++) begin
      set_beat(32'h100 + i, 5'(i));
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    tick(); tick();
    chk("t2_eight_out", n_out - base, 8);

    // 3: back-pressure, fill to FULL with A,B
    out_ready = 1'b0;
    base = n_out;
    set_beat(32'hAAAA_0001, 5'd10);
    in_valid = 1'b1;
    tick();
    set_beat(32'hBBBB_0002, 5'd11);
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    chk("t3_full_ready", in_ready, 1'b0);
    chk("t3_head_A", out_extimm, 32'hAAAA_0001);
    out_ready = 1'b1;
    tick(); tick(); tick();
    chk("t3_two_out", n_out - base, 2);
    chk("t3_empty", out_valid, 1'b0);

    // 4: flush while FULL with a beat arriving
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_beat(32'hC000_0000 + i, 5'(20 + i));
      in_valid = 1'b1;
      tick();
    end
    base = n_out;
    set_beat(32'hDEAD_BEEF, 5'd31);
    flush = 1'b1;
    out_ready = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("t4_head_xfer", n_out - base, 1);
    chk("t4_flushed_valid", out_valid, 1'b0);
    chk("t4_flushed_ready", in_ready, 1'b1);
    tick(); tick();

    // 5: async reset with two beats held
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_beat(32'hE000_0000 + i, 5'(5 + i));
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_valid", out_valid, 1'b0);
    chk("t5_ready", in_ready, 1'b1);
    chk("t5_payload", out_pl, '0);
    chk("t5_stall", stall_cnt, '0);
    q_exp.delete();
    exp_stall = '0;
    tick();
    rst_n = 1'b1;
    base = n_out;
    out_ready = 1'b1;
    tick(); tick(); tick();
    chk("t5_no_out", n_out - base, 0);

    // 6: stall counter saturation
    out_ready = 1'b0;
    set_beat(32'h5A5A_5A5A, 5'd7);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("t6_sat", stall_cnt, 4'hF);
    tick(); tick();
    chk("t6_sat_hold", stall_cnt, 4'hF);
    out_ready = 1'b1;
    tick(); tick();
    chk("t6_drained", q_exp.size(), 0);

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
